ads1292_sample_fifo: RTL and testbench

//  Elastic sample buffer between ads1292_filter and sensor_core. Accepts filtered
//  24-bit ECG samples via the filter's valid/ack handshake and re-presents them to

---
 rtl/khu_sensor_pkg.sv | 18 +
 rtl/sync_fifo_mem.sv | 40 ++++
 rtl/ads1292_sample_fifo.sv | 126 ++++++++++++
 tb/tb_ads1292_sample_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/khu_sensor_pkg.sv
// rtl/khu_sensor_pkg.sv - shared constants and types for the ADS1292 sample path
package khu_sensor_pkg;

  localparam int ADS_SAMPLE_W = 24;
  localparam int DROP_CNT_W   = 8;

  // Producer-side handshake state: one write per assertion of i_DATA_VALID
  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_LOW = 1'b1
  } in_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - 1W/1R register file with registered, write-through read
module sync_fifo_mem #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array: written on the clock edge, never reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; forwards the incoming word when it lands on the read slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_q <= wr_data_i;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ads1292_sample_fifo.sv
// rtl/ads1292_sample_fifo.sv - elastic ECG sample buffer with drop accounting
module ads1292_sample_fifo
  import khu_sensor_pkg::*;
#(
  parameter int DATA_W      = ADS_SAMPLE_W,
  parameter int DEPTH_LOG2  = 4,
  parameter bit DROP_OLDEST = 1'b1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic [DATA_W-1:0]     i_DATA,
  input  logic                  i_DATA_VALID,
  output logic                  o_DATA_ACK,
  output logic [DATA_W-1:0]     o_DATA,
  output logic                  o_DATA_VALID,
  input  logic                  i_DATA_ACK,
  input  logic                  i_CLEAR,
  output logic [DEPTH_LOG2:0]   o_COUNT,
  output logic                  o_OVERFLOW,
  output logic [DROP_CNT_W-1:0] o_DROP_CNT
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_MAX = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  in_state_e               state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    ack_q, ack_d;
  logic                    ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    full, empty, pop, wr_en, drop;

  // Handshake decode, pointer/count/flag next-state and the input FSM
  always_comb begin
    full     = (count_q == COUNT_MAX);
    empty    = (count_q == '0);
    pop      = i_DATA_ACK && !empty;
    wr_en    = (state_q == ST_IDLE) && i_DATA_VALID && (!full || DROP_OLDEST) && !i_CLEAR;
    // A write into a full buffer only displaces data when no pop frees a slot
    drop     = wr_en && full && !pop;
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ack_d    = 1'b0;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (i_CLEAR) begin
      // A sample present during the flush is discarded; wait for the producer to drop it
      state_d  = i_DATA_VALID ? ST_WAIT_LOW : ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      ack_d = wr_en;
      if (state_q == ST_IDLE) begin
        if (wr_en) state_d = ST_WAIT_LOW;
      end else begin
        if (!i_DATA_VALID) state_d = ST_IDLE;
      end
      if (wr_en)        wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop || drop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !pop && !full) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !wr_en) begin
        count_d = count_q - CNT_ONE;
      end
      if (drop) begin
        ovf_d  = 1'b1;
        drop_d = sat_inc(drop_q);
      end
    end
    valid_d = (count_d != '0);
  end

  // State, pointer and status registers
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Reading at the next read pointer keeps o_DATA aligned with o_DATA_VALID
  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk_i     (i_CLK),
    .rst_i     (i_RST),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (i_DATA),
    .rd_addr_i (rd_ptr_d),
    .rd_data_o (o_DATA)
  );

  assign o_DATA_ACK   = ack_q;
  assign o_DATA_VALID = valid_q;
  assign o_COUNT      = count_q;
  assign o_OVERFLOW   = ovf_q;
  assign o_DROP_CNT   = drop_q;

endmodule

// File: tb/tb_ads1292_sample_fifo.sv
// tb/tb_ads1292_sample_fifo.sv - self-checking bench for ads1292_sample_fifo
module tb_ads1292_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;

  logic [23:0] a_din, a_od;
  logic        a_dv, a_dack, a_ov, a_ack, a_clr, a_ovf;
  logic [4:0]  a_cnt;
  logic [7:0]  a_drop;

  logic [23:0] b_din, b_od;
  logic        b_dv, b_dack, b_ov, b_ack, b_clr, b_ovf;
  logic [4:0]  b_cnt;
  logic [7:0]  b_drop;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic [23:0] din;
    logic        dv;
    logic        ack;
    logic        clr;
    logic        e_dack;
    logic        e_ov;
    logic [23:0] e_od;
    logic [4:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  ads1292_sample_fifo #(.DATA_W(24), .DEPTH_LOG2(4), .DROP_OLDEST(1'b1)) dut (
    .i_CLK(clk), .i_RST(rst), .i_DATA(a_din), .i_DATA_VALID(a_dv), .o_DATA_ACK(a_dack),
    .o_DATA(a_od), .o_DATA_VALID(a_ov), .i_DATA_ACK(a_ack), .i_CLEAR(a_clr),
    .o_COUNT(a_cnt), .o_OVERFLOW(a_ovf), .o_DROP_CNT(a_drop)
  );

  ads1292_sample_fifo #(.DATA_W(24), .DEPTH_LOG2(4), .DROP_OLDEST(1'b0)) dut_stall (
    .i_CLK(clk), .i_RST(rst), .i_DATA(b_din), .i_DATA_VALID(b_dv), .o_DATA_ACK(b_dack),
    .o_DATA(b_od), .o_DATA_VALID(b_ov), .i_DATA_ACK(b_ack), .i_CLEAR(b_clr),
    .o_COUNT(b_cnt), .o_OVERFLOW(b_ovf), .o_DROP_CNT(b_drop)
  );

  function automatic vec_t mk(input logic r, input logic [23:0] d, input logic v,
                              input logic k, input logic c, input logic edk,
                              input logic eov, input logic [23:0] eod, input logic [4:0] ecnt);
    vec_t t;
    t.rst = r; t.din = d; t.dv = v; t.ack = k; t.clr = c;
    t.e_dack = edk; t.e_ov = eov; t.e_od = eod; t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Push one sample into the drop-oldest instance and mirror it in the model
  task automatic push_a(input logic [23:0] d);
    logic got;
    got   = 1'b0;
    a_din = d;
    a_dv  = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (a_dack) got = 1'b1;
    end
    a_dv = 1'b0;
    chk($sformatf("push_ack %0h", d), got, 1'b1);
    if (exp_q.size() == 16) void'(exp_q.pop_front());
    exp_q.push_back(d);
    chk($sformatf("push_count %0h", d), a_cnt, exp_q.size());
    tick();
  endtask

  // Pop the head of the drop-oldest instance and compare it with the model
  task automatic pop_a();
    logic [23:0] e;
    e = exp_q.pop_front();
    chk("pop_valid", a_ov, 1'b1);
    chk($sformatf("pop_data %0h", e), a_od, e);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("pop_count", a_cnt, exp_q.size());
  endtask

  task automatic push_b(input logic [23:0] d);
    logic got;
    got   = 1'b0;
    b_din = d;
    b_dv  = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (b_dack) got = 1'b1;
    end
    b_dv = 1'b0;
    chk($sformatf("stall_push_ack %0h", d), got, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_din = '0; a_dv = 1'b0; a_ack = 1'b0; a_clr = 1'b0;
    b_din = '0; b_dv = 1'b0; b_ack = 1'b0; b_clr = 1'b0;

    //          rst  din         dv   ack  clr  dack ov   od          cnt
    vq.push_back(mk(1, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 0));
    vq.push_back(mk(1, 24'h000000, 0, 0, 0, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'h123456, 1, 0, 0, 1, 1, 24'h123456, 1));
    vq.push_back(mk(0, 24'h123456, 0, 0, 0, 0, 1, 24'h123456, 1));
    vq.push_back(mk(0, 24'h000000, 0, 1, 0, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'h000000, 0, 1, 0, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'hABCDEF, 1, 0, 0, 1, 1, 24'hABCDEF, 1));
    vq.push_back(mk(0, 24'hABCDEF, 1, 0, 0, 0, 1, 24'hABCDEF, 1));
    vq.push_back(mk(0, 24'hABCDEF, 1, 0, 0, 0, 1, 24'hABCDEF, 1));
    vq.push_back(mk(0, 24'hABCDEF, 1, 0, 0, 0, 1, 24'hABCDEF, 1));
    vq.push_back(mk(0, 24'hABCDEF, 0, 0, 0, 0, 1, 24'hABCDEF, 1));
    vq.push_back(mk(0, 24'h111111, 1, 0, 0, 1, 1, 24'hABCDEF, 2));
    vq.push_back(mk(0, 24'h111111, 0, 1, 0, 0, 1, 24'h111111, 1));
    vq.push_back(mk(0, 24'h222222, 1, 1, 0, 1, 1, 24'h222222, 1));
    vq.push_back(mk(0, 24'h222222, 0, 0, 0, 0, 1, 24'h222222, 1));
    vq.push_back(mk(1, 24'h333333, 1, 0, 0, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'h333333, 1, 0, 0, 1, 1, 24'h333333, 1));
    vq.push_back(mk(0, 24'h333333, 0, 0, 1, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'h444444, 1, 0, 1, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'h444444, 1, 0, 0, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'h444444, 0, 0, 0, 0, 0, 24'h000000, 0));
    vq.push_back(mk(0, 24'h555555, 1, 0, 0, 1, 1, 24'h555555, 1));
    vq.push_back(mk(0, 24'h555555, 0, 1, 0, 0, 0, 24'h000000, 0));

    // Cycle-by-cycle vectors: reset, single pass, lingering valid, write+pop, reset and clear mid-handshake
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; a_din = vq[i].din; a_dv = vq[i].dv; a_ack = vq[i].ack; a_clr = vq[i].clr;
      tick();
      chk($sformatf("v%0d dack", i), a_dack, vq[i].e_dack);
      chk($sformatf("v%0d valid", i), a_ov, vq[i].e_ov);
      chk($sformatf("v%0d count", i), a_cnt, vq[i].e_cnt);
      chk($sformatf("v%0d overflow", i), a_ovf, 1'b0);
      chk($sformatf("v%0d drop_cnt", i), a_drop, 8'd0);
      if (vq[i].e_ov || vq[i].rst) chk($sformatf("v%0d data", i), a_od, vq[i].e_od);
      if (i == 1) begin
        chk("stall_reset_count", b_cnt, 5'd0);
        chk("stall_reset_valid", b_ov, 1'b0);
        chk("stall_reset_data", b_od, 24'h0);
      end
    end
    a_dv = 1'b0; a_ack = 1'b0; a_clr = 1'b0; rst = 1'b0;

    // Order and pointer wrap: 40 pushes, three pops per four pushes, then drain
    for (int i = 1; i <= 40; i++) begin
      push_a(24'(i));
      if ((i % 4) != 1) pop_a();
    end
    for (int i = 0; i < 16 && exp_q.size() > 0; i++) pop_a();
    chk("wrap_empty_valid", a_ov, 1'b0);
    chk("wrap_drop_cnt", a_drop, 8'd0);
    chk("wrap_overflow", a_ovf, 1'b0);

    // Overflow with drop-oldest: 20 pushes, no pops
    for (int i = 1; i <= 20; i++) push_a(24'h000100 + 24'(i));
    chk("ovf_count", a_cnt, 5'd16);
    chk("ovf_drop_cnt", a_drop, 8'd4);
    chk("ovf_flag", a_ovf, 1'b1);
    chk("ovf_head", a_od, 24'h000105);

    // Simultaneous push and pop at full: no drop, count holds
    a_din = 24'h000999; a_dv = 1'b1; a_ack = 1'b1;
    tick();
    a_dv = 1'b0; a_ack = 1'b0;
    chk("fullpp_dack", a_dack, 1'b1);
    chk("fullpp_count", a_cnt, 5'd16);
    chk("fullpp_drop_cnt", a_drop, 8'd4);
    chk("fullpp_head", a_od, 24'h000106);
    tick();

    // Clear while full, with push and pop requested in the same cycle
    a_clr = 1'b1; a_dv = 1'b1; a_ack = 1'b1; a_din = 24'h000AAA;
    tick();
    a_clr = 1'b0; a_ack = 1'b0;
    chk("clr_count", a_cnt, 5'd0);
    chk("clr_valid", a_ov, 1'b0);
    chk("clr_overflow", a_ovf, 1'b0);
    chk("clr_drop_cnt", a_drop, 8'd0);
    chk("clr_dack", a_dack, 1'b0);
    tick();
    chk("clr_linger_count", a_cnt, 5'd0);
    chk("clr_linger_dack", a_dack, 1'b0);
    a_dv = 1'b0;
    tick();
    exp_q.delete();

    // Stall mode: fill to 16, 17th push is held off until one pop
    for (int i = 0; i < 16; i++) push_b(24'h000200 + 24'(i));
    chk("stall_full_count", b_cnt, 5'd16);
    b_din = 24'h0002FF; b_dv = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (b_dack) seen = 1'b1;
      end
      chk("stall_no_ack", seen, 1'b0);
    end
    chk("stall_hold_count", b_cnt, 5'd16);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("stall_pop_count", b_cnt, 5'd15);
    chk("stall_pop_dack", b_dack, 1'b0);
    chk("stall_pop_head", b_od, 24'h000201);
    tick();
    chk("stall_late_dack", b_dack, 1'b1);
    chk("stall_late_count", b_cnt, 5'd16);
    b_dv = 1'b0;
    tick();
    chk("stall_overflow", b_ovf, 1'b0);
    chk("stall_drop_cnt", b_drop, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
